// File: rtl/conv_psum_relu.sv
// Accumulates CI channel partial-sum maps into a psum buffer and, on the last channel,
// adds the bias, applies ReLU/shift/saturation and streams one pixel per accepted input.
//
// state  | meaning
// S_IDLE | waiting for the first pixel of a frame (counters at 0, bias captured on accept)
// S_ACC  | accumulating channels 0..CI-2 into the psum buffer
// S_LAST | final channel: psum + input + bias produces an output pixel, no buffer write
module conv_psum_relu #(
    parameter int IBW    = 20,
    parameter int BW     = 20,
    parameter int I_SIZE = 24,
    parameter int CI     = 6,
    parameter int SHIFT  = 0
) (
    input  logic                  clk,
    input  logic                  global_rst_n,
    input  logic                  user_reset,
    input  logic                  i_valid,
    input  logic signed [IBW-1:0] i_data,
    input  logic signed [IBW-1:0] i_bias,
    output logic [BW-1:0]         o_data,
    output logic                  o_valid,
    output logic                  o_end,
    output logic                  o_busy
);

    localparam int NPIX = I_SIZE * I_SIZE;
    localparam int ACCW = IBW + $clog2(CI) + 1;
    localparam int SUMW = ACCW + 1;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = (CI > 1) ? $clog2(CI) : 1;
    localparam logic [SUMW+BW-1:0] MAXV = {{SUMW{1'b0}}, {BW{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_LAST} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PW-1:0]          r_pix;
    logic [CW-1:0]          r_ch;
    logic signed [IBW-1:0]  r_bias;
    logic [BW-1:0]          r_data;
    logic                   r_valid;
    logic                   r_fin;
    logic                   r_end;
    logic                   r_busy;
    logic signed [ACCW-1:0] r_buf [NPIX];

    logic                   w_pix_last;
    logic                   w_ch_last;
    logic                   w_ch_penult;
    logic                   w_buf_we;
    logic                   w_out_en;
    logic                   w_frame_done;
    logic signed [ACCW-1:0] w_din;
    logic signed [ACCW-1:0] w_rd;
    logic signed [ACCW-1:0] w_acc;
    logic signed [IBW-1:0]  w_bias_sel;
    logic signed [SUMW-1:0] w_sum;
    logic [SUMW-1:0]        w_shr;
    logic [SUMW+BW-1:0]     w_ext;
    logic [BW-1:0]          w_pix_out;

    assign w_pix_last  = (r_pix == PW'(NPIX - 1));
    assign w_ch_last   = (r_ch == CW'(CI - 1));
    assign w_ch_penult = (CI > 1) && (r_ch == CW'(CI - 2));

    assign w_din = {{(ACCW-IBW){i_data[IBW-1]}}, i_data};
    assign w_rd  = r_buf[r_pix];
    // Channel 0 overwrites, so stale buffer contents never leak into a new frame.
    assign w_acc = ((r_ch == '0) ? '0 : w_rd) + w_din;

    // In IDLE the bias register is loaded this same cycle, so a CI==1 frame uses i_bias directly.
    assign w_bias_sel = (r_state == S_IDLE) ? i_bias : r_bias;
    assign w_sum      = {w_acc[ACCW-1], w_acc} + {{(SUMW-IBW){w_bias_sel[IBW-1]}}, w_bias_sel};
    assign w_shr      = w_sum[SUMW-1] ? '0 : (w_sum >>> SHIFT);
    assign w_ext      = {{BW{1'b0}}, w_shr};
    assign w_pix_out  = (w_ext > MAXV) ? {BW{1'b1}} : w_ext[BW-1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_buf_we     = 1'b0;
        w_out_en     = 1'b0;
        w_frame_done = 1'b0;
        if (i_valid) begin
            w_buf_we     = !w_ch_last;
            w_out_en     = w_ch_last;
            w_frame_done = w_ch_last && w_pix_last;
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_frame_done)
                        w_state_nxt = S_IDLE;
                    else if ((CI == 1) || (w_ch_penult && w_pix_last))
                        w_state_nxt = S_LAST;
                    else
                        w_state_nxt = S_ACC;
                end
                S_LAST: begin
                    if (w_pix_last)
                        w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_state <= S_IDLE;
            r_pix   <= '0;
            r_ch    <= '0;
            r_bias  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fin   <= 1'b0;
            r_end   <= 1'b0;
            r_busy  <= 1'b0;
        end else if (user_reset) begin
            r_state <= S_IDLE;
            r_pix   <= '0;
            r_ch    <= '0;
            r_bias  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fin   <= 1'b0;
            r_end   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (i_valid) begin
                if (r_state == S_IDLE)
                    r_bias <= i_bias;
                if (w_pix_last) begin
                    r_pix <= '0;
                    r_ch  <= w_ch_last ? '0 : r_ch + CW'(1);
                end else begin
                    r_pix <= r_pix + PW'(1);
                end
            end
            r_valid <= w_out_en;
            if (w_out_en)
                r_data <= w_pix_out;
            // r_fin rides alongside the final o_valid; o_end follows one cycle later.
            r_fin  <= w_frame_done;
            r_end  <= r_fin;
            r_busy <= (w_state_nxt != S_IDLE) || w_frame_done || r_fin;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we && !user_reset)
            r_buf[r_pix] <= w_acc;
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_end   = r_end;
    assign o_busy  = r_busy;

endmodule
